// File: rtl/blit_pkg.sv
// Shared definitions for the blitter write path: FSM states, burst limits
// and the burst-contiguity rule used when collecting words into a burst.
package blit_pkg;

  localparam int unsigned BLIT_MAX_BURST_LIMIT = 4;
  localparam int unsigned BLIT_LEN_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REQUEST = 2'd2,
    ST_DATA    = 2'd3
  } blit_state_e;

  // A word extends the burst only if it is the next word and stays in the same 16-byte line
  function automatic logic blit_is_contiguous(
    input logic [23:0]           base,
    input logic [BLIT_LEN_W-1:0] count,
    input logic [23:0]           word_addr
  );
    logic [BLIT_LEN_W-1:0] line_pos;
    line_pos = {1'b0, base[1:0]} + count;
    return (word_addr == (base + {21'd0, count})) && (line_pos <= 3'd3);
  endfunction

endpackage

// File: rtl/blitter_write_master.sv
// Gathers word writes from the blitter FIFO into short contiguous bursts and
// issues them to the memory arbiter, one request/grant followed by the data beats.
module blitter_write_master
  import blit_pkg::*;
#(
  parameter int unsigned MAX_BURST     = 4,
  parameter int unsigned FLUSH_TIMEOUT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [25:0]           in_address,
  input  logic [3:0]            in_byte_en,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_request,
  output logic [25:0]           mem_address,
  output logic [BLIT_LEN_W-1:0] mem_burst_len,
  input  logic                  mem_grant,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_byte_en,
  input  logic                  mem_wdata_ready,
  output logic                  idle
);

  localparam int unsigned TO_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]       TO_LAST = TO_W'(FLUSH_TIMEOUT - 1);
  localparam logic [BLIT_LEN_W-1:0] MAX_CNT = BLIT_LEN_W'(MAX_BURST);

  blit_state_e           state_r, state_s;
  logic [23:0]           base_r, base_s;
  logic [BLIT_LEN_W-1:0] count_r, count_s;
  logic [1:0]            index_r, index_s;
  logic [TO_W-1:0]       timeout_r, timeout_s;
  logic                  load_s;
  logic [1:0]            load_slot_s;
  logic                  in_ready_s;
  logic                  contig_s;
  logic [23:0]           word_addr_s;
  logic [31:0]           buf_data_r [4];
  logic [3:0]            buf_be_r [4];
  logic                  unused_addr_lsb_s;

  assign word_addr_s       = in_address[25:2];
  assign unused_addr_lsb_s = ^in_address[1:0];

  // Next-state, buffer-load and handshake decode
  always_comb begin
    state_s     = state_r;
    base_s      = base_r;
    count_s     = count_r;
    index_s     = index_r;
    timeout_s   = timeout_r;
    load_s      = 1'b0;
    load_slot_s = count_r[1:0];
    in_ready_s  = 1'b0;
    contig_s    = blit_is_contiguous(base_r, count_r, word_addr_s);
    case (state_r)
      ST_IDLE: begin
        in_ready_s  = 1'b1;
        load_slot_s = 2'd0;
        if (in_valid && (in_byte_en != 4'd0)) begin
          load_s    = 1'b1;
          base_s    = word_addr_s;
          count_s   = 3'd1;
          index_s   = 2'd0;
          timeout_s = '0;
          if (MAX_CNT == 3'd1) begin
            state_s = ST_REQUEST;
          end else begin
            state_s = ST_COLLECT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (count_r >= MAX_CNT) begin
          state_s = ST_REQUEST;
        end else if (in_valid) begin
          // Zero-enable words are swallowed without touching the burst or the flush timer
          if (in_byte_en == 4'd0) begin
            in_ready_s = 1'b1;
          end else if (contig_s) begin
            in_ready_s = 1'b1;
            load_s     = 1'b1;
            count_s    = count_r + 3'd1;
            timeout_s  = '0;
            if (count_s == MAX_CNT) begin
              state_s = ST_REQUEST;
            end else begin
              state_s = ST_COLLECT;
            end
          end else begin
            state_s = ST_REQUEST;
          end
        end else begin
          if (timeout_r == TO_LAST) begin
            timeout_s = '0;
            state_s   = ST_REQUEST;
          end else begin
            timeout_s = timeout_r + TO_W'(1);
          end
        end
      end
      ST_REQUEST: begin
        if (mem_grant) begin
          index_s = 2'd0;
          state_s = ST_DATA;
        end else begin
          state_s = ST_REQUEST;
        end
      end
      ST_DATA: begin
        if (mem_wdata_ready) begin
          if (({1'b0, index_r} + 3'd1) == count_r) begin
            index_s = 2'd0;
            count_s = 3'd0;
            state_s = ST_IDLE;
          end else begin
            index_s = index_r + 2'd1;
          end
        end else begin
          index_s = index_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = 3'd0;
        index_s = 2'd0;
      end
    endcase
  end

  // Control registers; reset abandons any burst in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      base_r    <= 24'd0;
      count_r   <= 3'd0;
      index_r   <= 2'd0;
      timeout_r <= '0;
    end else begin
      state_r   <= state_s;
      base_r    <= base_s;
      count_r   <= count_s;
      index_r   <= index_s;
      timeout_r <= timeout_s;
    end
  end

  // Word buffer; contents are only meaningful below count, so no reset
  always_ff @(posedge clock) begin
    if (load_s) begin
      buf_data_r[load_slot_s] <= in_data;
      buf_be_r[load_slot_s]   <= in_byte_en;
    end
  end

  assign in_ready      = in_ready_s & reset;
  assign mem_request   = (state_r == ST_REQUEST);
  assign mem_address   = {base_r, 2'b00};
  assign mem_burst_len = count_r;
  assign mem_wdata     = buf_data_r[index_r];
  assign mem_byte_en   = buf_be_r[index_r];
  assign idle          = (state_r == ST_IDLE);

endmodule

// File: tb/tb_blitter_write_master.sv
// Directed bench: stimulus pushes expected bursts/words into queues, and a
// memory-side responder pops and compares as the DUT presents them.
module tb_blitter_write_master;

  typedef struct packed {logic [25:0] addr; logic [2:0] len;} req_t;
  typedef struct packed {logic [31:0] data; logic [3:0] be;} word_t;

  logic        clock;
  logic        reset;
  logic [25:0] in_address;
  logic [3:0]  in_byte_en;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_request;
  logic [25:0] mem_address;
  logic [2:0]  mem_burst_len;
  logic        mem_grant;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_wdata_ready;
  logic        idle;

  req_t  req_q[$];
  word_t data_q[$];
  int    n_vec = 0;
  int    n_miss = 0;
  int    grant_delay = 0;
  bit    ready_toggle = 1'b0;
  int    ready_limit = 99;
  int    words_seen = 0;

  blitter_write_master #(.MAX_BURST(4), .FLUSH_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .in_address(in_address), .in_byte_en(in_byte_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_request(mem_request), .mem_address(mem_address), .mem_burst_len(mem_burst_len),
    .mem_grant(mem_grant), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_wdata_ready(mem_wdata_ready), .idle(idle)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: event did not occur as expected", name);
  endtask

  task automatic expect_burst(input logic [25:0] a, input logic [2:0] l);
    req_t r;
    r.addr = a;
    r.len  = l;
    req_q.push_back(r);
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] be);
    word_t w;
    w.data = d;
    w.be   = be;
    data_q.push_back(w);
  endtask

  // Called at a falling edge; holds the word until accepted, returns at the next falling edge.
  task automatic drive_word(input logic [25:0] a, input logic [3:0] be, input logic [31:0] d,
                            input int exp_rdy);
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_address = a;
    in_byte_en = be;
    in_data    = d;
    #1;
    if (exp_rdy >= 0) check("in_ready_first", in_ready, exp_rdy[0]);
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (in_ready !== 1'b1) fail_now("accept_timeout");
    @(negedge clock);
  endtask

  task automatic drop();
    in_valid   = 1'b0;
    in_byte_en = 4'h0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(req_q.size() == 0 && data_q.size() == 0 && idle === 1'b1) && n < 400) begin
      @(negedge clock);
      n++;
    end
    check(name, (req_q.size() == 0 && data_q.size() == 0 && idle === 1'b1), 64'd1);
  endtask

  // Memory-side model: grants requests after grant_delay, paces data, compares against queues
  initial begin : responder
    req_t        er;
    word_t       ew;
    logic [25:0] a0;
    logic [2:0]  l0;
    bit          phase;
    bit          rdy;
    int          w;
    mem_grant       = 1'b0;
    mem_wdata_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && mem_request === 1'b1) begin
        a0 = mem_address;
        l0 = mem_burst_len;
        if (req_q.size() == 0) begin
          fail_now("req_unexpected");
        end else begin
          er = req_q.pop_front();
          check("req_addr", {38'd0, a0}, {38'd0, er.addr});
          check("req_len", {61'd0, l0}, {61'd0, er.len});
        end
        for (int k = 0; k < grant_delay && reset === 1'b1; k++) begin
          @(negedge clock);
          if (reset === 1'b1)
            check("req_stable", {34'd0, mem_request, mem_address, mem_burst_len},
                  {34'd0, 1'b1, a0, l0});
        end
        if (reset === 1'b1) begin
          mem_grant = 1'b1;
          @(negedge clock);
          mem_grant = 1'b0;
          w     = 0;
          phase = 1'b0;
          while (w < int'(l0) && reset === 1'b1) begin
            rdy   = (w < ready_limit) && (!ready_toggle || phase);
            phase = !phase;
            mem_wdata_ready = rdy;
            if (rdy) begin
              if (data_q.size() == 0) begin
                fail_now("data_unexpected");
              end else begin
                ew = data_q.pop_front();
                check("wdata", {32'd0, mem_wdata}, {32'd0, ew.data});
                check("wbyte_en", {60'd0, mem_byte_en}, {60'd0, ew.be});
              end
              w++;
              words_seen++;
            end
            @(negedge clock);
          end
          mem_wdata_ready = 1'b0;
        end
        mem_grant = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cycles;
    int ws0;
    int n;
    reset      = 1'b0;
    in_valid   = 1'b1;
    in_address = 26'h0;
    in_byte_en = 4'hF;
    in_data    = 32'h0;
    repeat (3) @(negedge clock);
    #1;
    check("reset_idle", idle, 64'd1);
    check("reset_mem_request", mem_request, 64'd0);
    check("reset_in_ready", in_ready, 64'd0);
    @(negedge clock);
    drop();
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_idle", idle, 64'd1);
    check("post_reset_in_ready", in_ready, 64'd1);

    // Four contiguous words fill one max-length burst
    expect_burst(26'h100, 3'd4);
    for (int i = 0; i < 4; i++) expect_word(32'hA000_0000 + 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) drive_word(26'h100 + 26'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), 1);
    drop();
    wait_drain("drain_four_words");

    // 16-byte line boundary splits the burst
    expect_burst(26'h108, 3'd2);
    expect_word(32'hB000_0000, 4'hF);
    expect_word(32'hB000_0001, 4'hF);
    expect_burst(26'h110, 3'd1);
    expect_word(32'hB000_0002, 4'hF);
    drive_word(26'h108, 4'hF, 32'hB000_0000, 1);
    drive_word(26'h10C, 4'hF, 32'hB000_0001, 1);
    drive_word(26'h110, 4'hF, 32'hB000_0002, 0);
    drop();
    wait_drain("drain_boundary");

    // Non-contiguous word is refused until the first burst completes
    expect_burst(26'h200, 3'd1);
    expect_word(32'hC000_0000, 4'hF);
    expect_burst(26'h300, 3'd1);
    expect_word(32'hC000_0001, 4'hF);
    drive_word(26'h200, 4'hF, 32'hC000_0000, 1);
    drive_word(26'h300, 4'hF, 32'hC000_0001, 0);
    drop();
    wait_drain("drain_noncontig");

    // Slow grant and toggling data-ready
    grant_delay  = 10;
    ready_toggle = 1'b1;
    expect_burst(26'h400, 3'd3);
    expect_word(32'hD000_0000, 4'h3);
    expect_word(32'hD000_0001, 4'hC);
    expect_word(32'hD000_0002, 4'h1);
    drive_word(26'h400, 4'h3, 32'hD000_0000, 1);
    drive_word(26'h404, 4'hC, 32'hD000_0001, 1);
    drive_word(26'h408, 4'h1, 32'hD000_0002, 1);
    drop();
    wait_drain("drain_slow_memory");
    grant_delay  = 0;
    ready_toggle = 1'b0;

    // Zero byte-enable word is dropped from the middle of a burst
    expect_burst(26'h100, 3'd2);
    expect_word(32'hE000_0000, 4'hF);
    expect_word(32'hE000_0001, 4'hF);
    drive_word(26'h100, 4'hF, 32'hE000_0000, 1);
    drive_word(26'h500, 4'h0, 32'hDEAD_BEEF, 1);
    drive_word(26'h104, 4'hF, 32'hE000_0001, 1);
    drop();
    wait_drain("drain_zero_be");

    // Single-word flush latency: request rises FLUSH_TIMEOUT edges after the accept edge
    expect_burst(26'h800, 3'd1);
    expect_word(32'hF000_0000, 4'hF);
    drive_word(26'h800, 4'hF, 32'hF000_0000, 1);
    drop();
    cycles = 0;
    while (mem_request !== 1'b1 && cycles < 50) begin
      @(negedge clock);
      cycles++;
    end
    check("flush_latency", 64'(cycles), 64'd4);
    wait_drain("drain_latency");

    // Reset during the data phase abandons the rest of the burst
    ready_limit = 1;
    ws0 = words_seen;
    expect_burst(26'h600, 3'd3);
    expect_word(32'h6000_0000, 4'hF);
    drive_word(26'h600, 4'hF, 32'h6000_0000, 1);
    drive_word(26'h604, 4'hF, 32'h6000_0001, 1);
    drive_word(26'h608, 4'hF, 32'h6000_0002, 1);
    drop();
    n = 0;
    while (words_seen == ws0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("reset_mid_words_delivered", 64'(words_seen - ws0), 64'd1);
    check("reset_mid_not_idle", idle, 64'd0);
    reset = 1'b0;
    #1;
    check("reset_mid_idle", idle, 64'd1);
    check("reset_mid_mem_request", mem_request, 64'd0);
    check("reset_mid_in_ready", in_ready, 64'd0);
    req_q.delete();
    data_q.delete();
    repeat (2) @(negedge clock);
    reset       = 1'b1;
    ready_limit = 99;
    @(negedge clock);

    // Normal traffic after the mid-burst reset
    expect_burst(26'h704, 3'd2);
    expect_word(32'h7000_0000, 4'h5);
    expect_word(32'h7000_0001, 4'hA);
    drive_word(26'h704, 4'h5, 32'h7000_0000, 1);
    drive_word(26'h708, 4'hA, 32'h7000_0001, 1);
    drop();
    wait_drain("drain_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
